sys_nios2_qsys_0_oci_dct_packer: RTL and testbench
==================================================

Name: sys_nios2_qsys_0_oci_dct_packer

Overview:
Upstream producer of the direction-compressed trace (DCT) word for the Nios II OCI trace path and its test bench. Packs per-branch 2-bit direction codes from the retire stage into a 30-bit shift buffer and exposes the live buffer and fill count (dct_buffer/dct_count). Completed or flushed frames go to a one-deep output register with a valid/ready handshake toward the trace FIFO. The CPU is never stalled; lost codes set a sticky overflow flag.

Parameters:
DCT_ENTRIES, 15, codes per frame; dct_count width is 4 bits
CODE_W, 2, bits per direction code
BUF_W, 30, frame width; must equal DCT_ENTRIES*CODE_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
trc_on  in  1  trace enable; when low, br_valid is ignored
br_valid  in  1  one branch retired this cycle
br_code  in  2  01 not-taken, 10 taken, 11 exception marker; 00 is reserved and ignored (no insert)
flush_req  in  1  close the current partial frame (indirect jump, trace stop)
dct_buffer  out  30  live shift buffer; newest code in [1:0]
dct_count  out  4  codes currently in dct_buffer, 0..15
frm_valid  out  1  output frame register holds a frame
frm_data  out  30  frame contents, same packing as dct_buffer
frm_count  out  4  valid codes in frm_data, 1..15
frm_ready  in  1  downstream accepts the frame when frm_valid & frm_ready
overflow  out  1  sticky: a code or flush was dropped
clr_overflow  in  1  clears overflow; set takes priority in the same cycle

Behaviour:
- Reset (async, active-high): dct_buffer=0, dct_count=0, frm_valid=0, frm_data=0, frm_count=0, overflow=0, FSM=FILL. Reset mid-operation discards the partial and pending frames.
- insert = trc_on & br_valid & (br_code!=00).
- Insert: dct_buffer <= {dct_buffer[27:0], br_code}; dct_count <= dct_count+1.
- close = (insert & dct_count==14) | (flush_req & (dct_count + insert) > 0). Flush with an empty buffer and no insert is a no-op.
- out_free = ~frm_valid | frm_ready.
- On close with out_free: frm_data <= post-insert buffer; frm_count <= post-insert count; frm_valid <= 1; dct_buffer <= 0; dct_count <= 0.
- Latency: a frame is visible on frm_* in the cycle after the closing insert or flush.
- Simultaneous insert and flush in one cycle: the code is inserted first, then the frame is closed including that code.
- FSM, 2 states:
  - FILL: normal accumulation. On close with ~out_free, go to HOLD and keep buffer and count (count 15 if closed by fill, otherwise the partial count).
  - HOLD: buffer is frozen. Any insert is dropped and sets overflow. A flush_req in HOLD is dropped and sets overflow, except that it is redundant when the buffer already holds the closed frame. When out_free, move the held buffer to the output register as above, clear the buffer, return to FILL. An insert in that same transfer cycle is dropped (overflow=1).
- Handshake: frm_data/frm_count stay stable while frm_valid & ~frm_ready. frm_valid falls after an accepted transfer unless a new frame loads in the same cycle (back-to-back, no bubble).
- dct_count never exceeds 15. No wrap: a full buffer always closes or holds.
- trc_on low does not flush. Pending contents persist until flush_req.
- overflow: set on any dropped insert or flush; cleared by clr_overflow only if no set occurs that cycle.

Test Plan:
- Fill: 15 inserts of code 10 with frm_ready=1 -> one cycle after the 15th, frm_valid=1, frm_data=0x2AAAAAAA, frm_count=15; dct_count=0.
- Partial flush: inserts 01,10,11 then flush_req -> frm_data=0x0000001B, frm_count=3, overflow=0.
- Same-cycle insert and flush: buffer holding {01}, insert 10 with flush_req -> frm_data=0x6, frm_count=2.
- Backpressure: frm_ready=0 with one frame pending, 15 more inserts -> state HOLD, dct_count=15; 16th insert -> overflow=1, buffer unchanged; raise frm_ready -> second frame loads next cycle, no bubble.
- Code 00 and trc_on=0 inserts -> dct_count unchanged; flush with empty buffer -> frm_valid stays 0.
- Assert reset mid-fill (dct_count=7, frm_valid=1) -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sys_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit branch direction codes into 30-bit DCT frames.
// Closed frames go to a one-deep valid/ready output register.
module sys_nios2_qsys_0_oci_dct_packer #(
    parameter int DCT_ENTRIES = 15,
    parameter int CODE_W      = 2,
    parameter int BUF_W       = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trc_on,
    input  logic              br_valid,
    input  logic [CODE_W-1:0] br_code,
    input  logic              flush_req,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [3:0]        dct_count,
    output logic              frm_valid,
    output logic [BUF_W-1:0]  frm_data,
    output logic [3:0]        frm_count,
    input  logic              frm_ready,
    output logic              overflow,
    input  logic              clr_overflow
);

    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [3:0] LAST = 4'(DCT_ENTRIES - 1);

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              frm_valid_q, frm_valid_d;
    logic [BUF_W-1:0]  frm_data_q, frm_data_d;
    logic [3:0]        frm_count_q, frm_count_d;
    logic              ovf_q, ovf_d;

    logic              insert, out_free, close, ovf_set, load;
    logic [BUF_W-1:0]  post_buf, load_buf;
    logic [3:0]        post_cnt, load_cnt;

    always_comb begin
        insert   = trc_on & br_valid & (br_code != '0);
        out_free = ~frm_valid_q | frm_ready;
        post_buf = insert ? {buf_q[BUF_W-CODE_W-1:0], br_code} : buf_q;
        post_cnt = insert ? cnt_q + 4'd1 : cnt_q;
        close    = (insert & (cnt_q == LAST)) |
                   (flush_req & (post_cnt != 4'd0));

        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        frm_valid_d = frm_valid_q & ~frm_ready;
        frm_data_d  = frm_data_q;
        frm_count_d = frm_count_q;
        ovf_set     = 1'b0;
        load        = 1'b0;
        load_buf    = '0;
        load_cnt    = '0;

        unique case (state_q)
            FILL: begin
                if (close && out_free) begin
                    load     = 1'b1;
                    load_buf = post_buf;
                    load_cnt = post_cnt;
                    buf_d    = '0;
                    cnt_d    = '0;
                end else begin
                    buf_d = post_buf;
                    cnt_d = post_cnt;
                    if (close) state_d = HOLD;
                end
            end
            HOLD: begin
                // Buffer already holds the closed frame, so a flush here
                // is redundant; only new codes are lost.
                ovf_set = insert;
                if (out_free) begin
                    load     = 1'b1;
                    load_buf = buf_q;
                    load_cnt = cnt_q;
                    buf_d    = '0;
                    cnt_d    = '0;
                    state_d  = FILL;
                end
            end
        endcase

        if (load) begin
            frm_valid_d = 1'b1;
            frm_data_d  = load_buf;
            frm_count_d = load_cnt;
        end

        ovf_d = ovf_set ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            buf_q       <= '0;
            cnt_q       <= '0;
            frm_valid_q <= 1'b0;
            frm_data_q  <= '0;
            frm_count_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            frm_valid_q <= frm_valid_d;
            frm_data_q  <= frm_data_d;
            frm_count_q <= frm_count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign frm_valid  = frm_valid_q;
    assign frm_data   = frm_data_q;
    assign frm_count  = frm_count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_sys_nios2_qsys_0_oci_dct_packer.sv
// Bench for the DCT packer: queue-based reference model feeding a
// frame scoreboard, plus directed corner cases and async reset.
module tb_sys_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trc_on = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  br_code = 2'b00;
    logic        flush_req = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frm_valid;
    logic [29:0] frm_data;
    logic [3:0]  frm_count;
    logic        frm_ready = 1'b0;
    logic        overflow;
    logic        clr_overflow = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit [1:0]  m_part[$];
    bit        m_hold = 0;
    bit        m_ov   = 0;
    bit        m_ovf  = 0;
    bit [33:0] exp_q[$];

    sys_nios2_qsys_0_oci_dct_packer dut (
        .clk          (clk),
        .reset        (rst),
        .trc_on       (trc_on),
        .br_valid     (br_valid),
        .br_code      (br_code),
        .flush_req    (flush_req),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .frm_valid    (frm_valid),
        .frm_data     (frm_data),
        .frm_count    (frm_count),
        .frm_ready    (frm_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit [29:0] pack(input bit [1:0] q[$]);
        bit [29:0] d = '0;
        foreach (q[i]) d = (d << 2) | 30'(q[i]);
        return d;
    endfunction

    // Called at posedge+1: checks the current state, then applies one
    // cycle of stimulus to both DUT and model.
    task automatic step(input bit trc, input bit bv, input bit [1:0] code,
                        input bit fl, input bit rdy, input bit clr);
        bit ins, free, close, set, load;
        chk("dct_count", 32'(dct_count), 32'(m_part.size()));
        chk("dct_buffer", 32'(dct_buffer), 32'(pack(m_part)));
        chk("frm_valid", 32'(frm_valid), 32'(m_ov));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        trc_on = trc; br_valid = bv; br_code = code;
        flush_req = fl; frm_ready = rdy; clr_overflow = clr;
        ins  = trc && bv && (code != 2'b00);
        free = !m_ov || rdy;
        set  = 0;
        load = 0;
        if (!m_hold) begin
            if (ins) m_part.push_back(code);
            close = (ins && m_part.size() == 15) ||
                    (fl && m_part.size() > 0);
            if (close) begin
                if (free) load = 1;
                else m_hold = 1;
            end
        end else begin
            set = ins;
            if (free) begin
                load = 1;
                m_hold = 0;
            end
        end
        if (load) begin
            exp_q.push_back({4'(m_part.size()), pack(m_part)});
            m_part.delete();
            m_ov = 1;
        end else if (rdy) begin
            m_ov = 0;
        end
        if (set) m_ovf = 1;
        else if (clr) m_ovf = 0;
        @(posedge clk);
        #1;
    endtask

    // frame scoreboard: each accepted frame must match the oldest expected
    always @(negedge clk) begin
        if (!rst && frm_valid && frm_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'(frm_data), 32'hFFFFFFFF);
            end else begin
                bit [33:0] e;
                e = exp_q.pop_front();
                chk("frm_data", 32'(frm_data), 32'(e[29:0]));
                chk("frm_count", 32'(frm_count), 32'(e[33:30]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        chk("rst_count", 32'(dct_count), 0);
        chk("rst_buffer", 32'(dct_buffer), 0);
        chk("rst_valid", 32'(frm_valid), 0);
        chk("rst_data", 32'(frm_data), 0);
        chk("rst_fcount", 32'(frm_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // full frame of taken branches
        repeat (15) step(1, 1, 2'b10, 0, 1, 0);
        chk("fill_valid", 32'(frm_valid), 1);
        chk("fill_data", 32'(frm_data), 32'h2AAAAAAA);
        chk("fill_count", 32'(frm_count), 15);
        chk("fill_dct_count", 32'(dct_count), 0);

        // partial flush
        step(1, 1, 2'b01, 0, 1, 0);
        step(1, 1, 2'b10, 0, 1, 0);
        step(1, 1, 2'b11, 0, 1, 0);
        step(0, 0, 2'b00, 1, 1, 0);
        chk("part_data", 32'(frm_data), 32'h1B);
        chk("part_count", 32'(frm_count), 3);
        chk("part_ovf", 32'(overflow), 0);

        // insert and flush in the same cycle
        step(1, 1, 2'b01, 0, 1, 0);
        step(1, 1, 2'b10, 1, 1, 0);
        chk("same_data", 32'(frm_data), 32'h6);
        chk("same_count", 32'(frm_count), 2);

        // backpressure into HOLD, then overflow
        repeat (15) step(1, 1, 2'b11, 0, 0, 0);
        chk("hold_count", 32'(dct_count), 15);
        chk("hold_stable", 32'(frm_data), 32'h6);
        step(1, 1, 2'b11, 0, 0, 0);
        chk("hold_ovf", 32'(overflow), 1);
        chk("hold_buf", 32'(dct_buffer), 32'h3FFFFFFF);
        step(0, 0, 2'b00, 0, 1, 0);
        chk("b2b_valid", 32'(frm_valid), 1);
        chk("b2b_data", 32'(frm_data), 32'h3FFFFFFF);
        chk("b2b_count", 32'(frm_count), 15);
        step(0, 0, 2'b00, 0, 1, 1);
        chk("clr_ovf", 32'(overflow), 0);

        // ignored inserts and empty flush
        step(1, 1, 2'b00, 0, 1, 0);
        step(0, 1, 2'b10, 0, 1, 0);
        chk("ignored_count", 32'(dct_count), 0);
        step(0, 0, 2'b00, 1, 1, 0);
        chk("empty_flush", 32'(frm_valid), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 6,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) < 65,
                 $urandom_range(0, 19) == 0);
        end
        repeat (3) step(0, 0, 2'b00, 1, 1, 0);
        repeat (2) step(0, 0, 2'b00, 0, 1, 0);

        // async reset in the middle of a fill
        step(1, 1, 2'b01, 1, 0, 0);
        repeat (7) step(1, 1, 2'b10, 0, 0, 0);
        chk("pre_rst_count", 32'(dct_count), 7);
        chk("pre_rst_valid", 32'(frm_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(dct_count), 0);
        chk("arst_buffer", 32'(dct_buffer), 0);
        chk("arst_valid", 32'(frm_valid), 0);
        chk("arst_data", 32'(frm_data), 0);
        chk("arst_fcount", 32'(frm_count), 0);
        chk("arst_ovf", 32'(overflow), 0);
        m_part.delete();
        m_hold = 0;
        m_ov = 0;
        m_ovf = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(1, 1, 2'b11, 0, 1, 0);
        step(0, 0, 2'b00, 1, 1, 0);
        repeat (2) step(0, 0, 2'b00, 0, 1, 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
